multicycle_seq: RTL and testbench

Multi-cycle instruction sequencer for the 4-bit-opcode datapath. Fetches 16-bit instructions over a req/ack handshake, decodes the opcode, and sequences the ALU, register-file write and data-memory access across separate cycles. It drives the register-file write enable, the ALU operation code, the writeback mux select and the memory W/R strobes. It sits between instruction memory, data memory and the existing register file/ALU datapath.

---
 rtl/multicycle_seq_pkg.sv | 46 ++++
 rtl/multicycle_seq_if.sv | 30 +++
 rtl/multicycle_seq_op_decode.sv | 33 +++
 rtl/multicycle_seq.sv | 149 ++++++++++++++
 tb/tb_multicycle_seq.sv | 399 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_seq_pkg.sv
// Shared opcode, ALU-code, state and instruction-class definitions for the sequencer.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package seq_pkg;

    localparam int IW = 16;

    // Opcodes in instruction bits [15:12]
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_NOR  = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ALU operation codes driven to the datapath
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // Illegal opcodes decode as CL_NOP so they retire like a NOP
    typedef enum logic [2:0] {
        CL_NOP  = 3'd0,
        CL_ALU  = 3'd1,
        CL_SW   = 3'd2,
        CL_LW   = 3'd3,
        CL_HALT = 3'd4
    } op_class_t;

endpackage

// File: rtl/multicycle_seq_if.sv
// Fetch, data-memory and register-file/ALU control bundle of the sequencer.
// Latency: none (wiring only).
// Backpressure: imem_ack and dmem_ready stretch the fetch and memory phases.
interface multicycle_seq_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [15:0]     imem_data;
    logic [3:0]      rd;
    logic [3:0]      rs1;
    logic [3:0]      rs2;
    logic            WE;
    logic            demux_sel;
    logic [3:0]      alucode;
    logic            W;
    logic            R;
    logic            dmem_ready;

    modport master (
        output imem_req, imem_addr, rd, rs1, rs2, WE, demux_sel, alucode, W, R,
        input  imem_ack, imem_data, dmem_ready
    );

    modport slave (
        input  imem_req, imem_addr, rd, rs1, rs2, WE, demux_sel, alucode, W, R,
        output imem_ack, imem_data, dmem_ready
    );
endinterface

// File: rtl/multicycle_seq_op_decode.sv
// Opcode table: instruction class, ALU code and illegal flag.
// Latency: combinational.
// Backpressure: none.
module op_decode
    import seq_pkg::*;
(
    input  logic [3:0] opcode,
    output op_class_t  cls,
    output logic [3:0] alucode,
    output logic       illegal
);

    // SW/LW keep the ADD code: the ALU forms the memory address
    always_comb begin
        cls     = CL_NOP;
        alucode = ALU_ADD;
        illegal = 1'b0;
        case (opcode)
            OP_NOP:  cls = CL_NOP;
            OP_ADD:  begin cls = CL_ALU; alucode = ALU_ADD; end
            OP_SUB:  begin cls = CL_ALU; alucode = ALU_SUB; end
            OP_AND:  begin cls = CL_ALU; alucode = ALU_AND; end
            OP_OR:   begin cls = CL_ALU; alucode = ALU_OR;  end
            OP_XOR:  begin cls = CL_ALU; alucode = ALU_XOR; end
            OP_NOR:  begin cls = CL_ALU; alucode = ALU_NOR; end
            OP_SW:   cls = CL_SW;
            OP_LW:   cls = CL_LW;
            OP_HALT: cls = CL_HALT;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle sequencer: fetch, decode, exec, mem, writeback for the 4-bit-opcode datapath.
// Latency: NOP 2, ALU/SW 4, LW 5 cycles minimum; control outputs registered.
// Backpressure: FETCH waits on imem_ack, MEM waits on dmem_ready; strobes hold steady meanwhile.
module multicycle_seq
    import seq_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    multicycle_seq_if.master bus,
    output logic [PC_W-1:0]  pc,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_t     state, state_d;
    logic [15:0] ir, ir_d;
    op_class_t  cls;
    logic [3:0] dec_alu;
    logic       dec_ill;
    logic       fetch_done;
    logic       retire;

    logic       we_d, dsel_d, w_d, r_d, halted_d, ill_d;
    logic [3:0] alu_d;
    logic       we_q, dsel_q, w_q, r_q;
    logic [3:0] alu_q;

    assign fetch_done = (state == S_FETCH) && bus.imem_ack;

    // Decode the IR as it will be next cycle, so registered outputs line up with the new state
    assign ir_d = fetch_done ? bus.imem_data : ir;

    op_decode u_op_decode (
        .opcode  (ir_d[15:12]),
        .cls     (cls),
        .alucode (dec_alu),
        .illegal (dec_ill)
    );

    // Next-state and retire decision
    always_comb begin
        state_d = state;
        retire  = 1'b0;
        case (state)
            S_FETCH:  if (bus.imem_ack) state_d = S_DECODE;
            S_DECODE: begin
                if (cls == CL_NOP) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (cls == CL_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC:   state_d = (cls == CL_ALU) ? S_WB : S_MEM;
            S_MEM: begin
                if (bus.dmem_ready) begin
                    if (cls == CL_SW) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Control outputs for the state being entered
    always_comb begin
        we_d     = 1'b0;
        dsel_d   = 1'b0;
        w_d      = 1'b0;
        r_d      = 1'b0;
        halted_d = 1'b0;
        ill_d    = 1'b0;
        alu_d    = 4'b0000;
        case (state_d)
            S_DECODE: ill_d = dec_ill;
            S_EXEC:   alu_d = dec_alu;
            S_MEM: begin
                alu_d  = dec_alu;
                dsel_d = 1'b1;
                w_d    = (cls == CL_SW);
                r_d    = (cls == CL_LW);
            end
            S_WB: begin
                alu_d  = dec_alu;
                we_d   = 1'b1;
                dsel_d = (cls == CL_LW);
            end
            S_HALT:   halted_d = 1'b1;
            default:  ;
        endcase
    end

    // Sequencer state, pc, IR, retire counter and registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            ir      <= '0;
            pc      <= '0;
            instret <= '0;
            we_q    <= 1'b0;
            dsel_q  <= 1'b0;
            w_q     <= 1'b0;
            r_q     <= 1'b0;
            alu_q   <= 4'b0000;
            halted  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state <= state_d;
            ir    <= ir_d;
            if (fetch_done) pc <= pc + PC_W'(1);
            if (retire) instret <= instret + CNT_W'(1);
            we_q    <= we_d;
            dsel_q  <= dsel_d;
            w_q     <= w_d;
            r_q     <= r_d;
            alu_q   <= alu_d;
            halted  <= halted_d;
            illegal <= ill_d;
        end
    end

    // Fetch request is gated by reset so it is low while rst_n is held
    assign bus.imem_req  = rst_n && (state == S_FETCH);
    assign bus.imem_addr = pc;
    assign bus.rd        = ir[11:8];
    assign bus.rs1       = ir[7:4];
    assign bus.rs2       = ir[3:0];
    assign bus.WE        = we_q;
    assign bus.demux_sel = dsel_q;
    assign bus.alucode   = alu_q;
    assign bus.W         = w_q;
    assign bus.R         = r_q;

endmodule

// File: tb/tb_multicycle_seq.sv
// Self-checking bench for multicycle_seq: scenario tasks plus a writeback scoreboard.
// Latency: n/a.
// Backpressure: bench models imem_ack / dmem_ready delays.
module tb_multicycle_seq;

    typedef struct packed {
        logic [3:0] rd;
        logic       dsel;
        logic [3:0] alu;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pc;
    logic        halted;
    logic        illegal;
    logic [15:0] instret;

    int          checks = 0;
    int          failures = 0;
    int          exp_ret = 0;
    logic [7:0]  exp_pc = 8'h00;
    wb_t         wb_q[$];

    multicycle_seq_if #(.PC_W(8)) bus ();

    multicycle_seq #(.PC_W(8), .CNT_W(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .pc      (pc),
        .halted  (halted),
        .illegal (illegal),
        .instret (instret)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ref_alu(input logic [3:0] op);
        case (op)
            4'h1:    return 4'b0000;
            4'h2:    return 4'b0001;
            4'h3:    return 4'b0010;
            4'h4:    return 4'b0110;
            4'h5:    return 4'b0111;
            4'h6:    return 4'b1100;
            default: return 4'b0000;
        endcase
    endfunction

    // Every register-file write must match the next queued expectation
    always @(negedge clk) begin : wb_monitor
        wb_t e;
        if (rst_n === 1'b1 && bus.WE === 1'b1) begin
            checks++;
            if (wb_q.size() == 0) begin
                failures++;
                $display("FAIL wb_unexpected: WE=1 rd=%0d, no write expected", bus.rd);
            end else begin
                e = wb_q.pop_front();
                if ({bus.rd, bus.demux_sel, bus.alucode} !== e) begin
                    failures++;
                    $display("FAIL wb_fields: got rd/dsel/alu=%h required %h",
                             {bus.rd, bus.demux_sel, bus.alucode}, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a fetch request, then ack after ack_delay cycles
    task automatic issue(input logic [15:0] instr, input int ack_delay);
        int n;
        n = 0;
        while (bus.imem_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (bus.imem_req !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL fetch_timeout: imem_req=%b required 1", bus.imem_req);
            return;
        end
        repeat (ack_delay) tick();
        bus.imem_ack  = 1'b1;
        bus.imem_data = instr;
        tick();
        exp_pc++;
        bus.imem_ack  = 1'b0;
        bus.imem_data = 16'hF0F0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_data = 16'h0000;
        bus.dmem_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.imem_req, bus.WE, bus.demux_sel, bus.W, bus.R, bus.alucode, halted, illegal} !== 11'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b required 0",
                     {bus.imem_req, bus.WE, bus.demux_sel, bus.W, bus.R, bus.alucode, halted, illegal});
        end
        checks++;
        if (pc !== 8'h00 || instret !== 16'h0000) begin
            failures++;
            $display("FAIL reset_regs: pc=%h instret=%h required 0", pc, instret);
        end
        rst_n = 1'b1;
        exp_ret = 0;
        exp_pc = 8'h00;
        #1;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin
            failures++;
            $display("FAIL first_fetch: req=%b addr=%h required 1/00", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_alu_basic();
        wb_q.push_back({4'h1, 1'b0, 4'b0000});
        issue(16'h1123, 0);
        checks++;
        if ({bus.imem_req, illegal, bus.WE} !== 3'b000 || {bus.rd, bus.rs1, bus.rs2} !== 12'h123) begin
            failures++;
            $display("FAIL alu_decode: req/ill/we=%b ir=%h required 000/123",
                     {bus.imem_req, illegal, bus.WE}, {bus.rd, bus.rs1, bus.rs2});
        end
        tick();
        checks++;
        if (bus.WE !== 1'b0 || bus.alucode !== 4'b0000) begin
            failures++;
            $display("FAIL alu_exec: WE=%b alucode=%b required 0/0000", bus.WE, bus.alucode);
        end
        tick();
        checks++;
        if ({bus.WE, bus.demux_sel, bus.alucode, bus.rd} !== {1'b1, 1'b0, 4'h0, 4'h1} || pc !== 8'h01) begin
            failures++;
            $display("FAIL alu_wb_cycle4: we/dsel/alu/rd=%h pc=%h required 11/01",
                     {bus.WE, bus.demux_sel, bus.alucode, bus.rd}, pc);
        end
        tick();
        exp_ret++;
        checks++;
        if (instret !== exp_ret[15:0] || bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc) begin
            failures++;
            $display("FAIL alu_retire: instret=%0d req=%b addr=%h required %0d/1/%h",
                     instret, bus.imem_req, bus.imem_addr, exp_ret, exp_pc);
        end
    endtask

    task automatic test_alu_ops();
        for (int op = 1; op <= 6; op++) begin
            logic [15:0] ins;
            ins = {op[3:0], 4'($urandom), 8'($urandom)};
            wb_q.push_back({ins[11:8], 1'b0, ref_alu(op[3:0])});
            issue(ins, 0);
            tick();
            checks++;
            if (bus.alucode !== ref_alu(op[3:0])) begin
                failures++;
                $display("FAIL alu_code op=%0d: got %b required %b", op, bus.alucode, ref_alu(op[3:0]));
            end
            tick();
            checks++;
            if (bus.WE !== 1'b1 || bus.alucode !== ref_alu(op[3:0])) begin
                failures++;
                $display("FAIL alu_wb op=%0d: WE=%b alucode=%b required 1/%b",
                         op, bus.WE, bus.alucode, ref_alu(op[3:0]));
            end
            tick();
            exp_ret++;
            checks++;
            if (instret !== exp_ret[15:0]) begin
                failures++;
                $display("FAIL alu_instret op=%0d: got %0d required %0d", op, instret, exp_ret);
            end
        end
    endtask

    task automatic test_sw();
        issue(16'h7345, 0);
        tick();
        checks++;
        if ({bus.alucode, bus.W, bus.R} !== 6'b0) begin
            failures++;
            $display("FAIL sw_exec: alu/W/R=%b required 0", {bus.alucode, bus.W, bus.R});
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus.W, bus.demux_sel, bus.R, bus.WE} !== 4'b1100) begin
                failures++;
                $display("FAIL sw_mem cycle %0d: W/dsel/R/WE=%b required 1100",
                         i, {bus.W, bus.demux_sel, bus.R, bus.WE});
            end
            if (i == 3) bus.dmem_ready = 1'b1;
            tick();
        end
        bus.dmem_ready = 1'b0;
        exp_ret++;
        checks++;
        if ({bus.imem_req, bus.W, bus.demux_sel} !== 3'b100 || instret !== exp_ret[15:0]) begin
            failures++;
            $display("FAIL sw_done: req/W/dsel=%b instret=%0d required 100/%0d",
                     {bus.imem_req, bus.W, bus.demux_sel}, instret, exp_ret);
        end
    endtask

    task automatic test_lw();
        wb_q.push_back({4'h6, 1'b1, 4'b0000});
        issue(16'h86AB, 0);
        tick();
        checks++;
        if (bus.R !== 1'b0 || bus.alucode !== 4'b0000) begin
            failures++;
            $display("FAIL lw_exec: R=%b alucode=%b required 0/0000", bus.R, bus.alucode);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bus.R, bus.demux_sel, bus.W, bus.WE} !== 4'b1100) begin
                failures++;
                $display("FAIL lw_mem cycle %0d: R/dsel/W/WE=%b required 1100",
                         i, {bus.R, bus.demux_sel, bus.W, bus.WE});
            end
            if (i == 2) bus.dmem_ready = 1'b1;
            tick();
        end
        bus.dmem_ready = 1'b0;
        checks++;
        if ({bus.WE, bus.demux_sel, bus.R, bus.W} !== 4'b1100) begin
            failures++;
            $display("FAIL lw_wb: WE/dsel/R/W=%b required 1100", {bus.WE, bus.demux_sel, bus.R, bus.W});
        end
        tick();
        exp_ret++;
        checks++;
        if (instret !== exp_ret[15:0] || bus.imem_req !== 1'b1) begin
            failures++;
            $display("FAIL lw_retire: instret=%0d req=%b required %0d/1", instret, bus.imem_req, exp_ret);
        end
    endtask

    task automatic test_fetch_wait();
        bus.dmem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc) begin
                failures++;
                $display("FAIL fetch_wait cycle %0d: req=%b addr=%h required 1/%h",
                         i, bus.imem_req, bus.imem_addr, exp_pc);
            end
            tick();
        end
        bus.dmem_ready = 1'b0;
        wb_q.push_back({4'hE, 1'b0, 4'b0001});
        issue(16'h2E01, 0);
        repeat (3) tick();
        exp_ret++;
        checks++;
        if (instret !== exp_ret[15:0]) begin
            failures++;
            $display("FAIL fetch_wait_retire: instret=%0d required %0d", instret, exp_ret);
        end
    endtask

    task automatic test_illegal_nop();
        issue(16'hA123, 0);
        checks++;
        if ({illegal, bus.WE, bus.W, bus.R} !== 4'b1000) begin
            failures++;
            $display("FAIL illegal_decode: ill/WE/W/R=%b required 1000", {illegal, bus.WE, bus.W, bus.R});
        end
        tick();
        checks++;
        if ({illegal, bus.imem_req} !== 2'b01 || bus.imem_addr !== exp_pc) begin
            failures++;
            $display("FAIL illegal_after: ill/req=%b addr=%h required 01/%h",
                     {illegal, bus.imem_req}, bus.imem_addr, exp_pc);
        end
        issue(16'h0000, 0);
        checks++;
        if ({illegal, bus.WE, bus.W, bus.R} !== 4'b0000) begin
            failures++;
            $display("FAIL nop_decode: ill/WE/W/R=%b required 0000", {illegal, bus.WE, bus.W, bus.R});
        end
        tick();
        exp_ret += 2;
        checks++;
        if (instret !== exp_ret[15:0] || bus.imem_req !== 1'b1) begin
            failures++;
            $display("FAIL illegal_nop_retire: instret=%0d req=%b required %0d/1", instret, bus.imem_req, exp_ret);
        end
    endtask

    task automatic test_reset_mid();
        issue(16'h8123, 0);
        repeat (2) tick();
        checks++;
        if (bus.R !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre: R=%b required 1", bus.R);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.R !== 1'b0 || bus.demux_sel !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_async: R=%b dsel=%b required 0/0", bus.R, bus.demux_sel);
        end
        checks++;
        if (pc !== 8'h00 || instret !== 16'h0000) begin
            failures++;
            $display("FAIL rst_mid_regs: pc=%h instret=%h required 0/0", pc, instret);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        exp_ret = 0;
        exp_pc = 8'h00;
        #1;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid_fetch: req=%b addr=%h required 1/00", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_wrap_halt();
        for (int i = 0; i < 258; i++) begin
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc) begin
                failures++;
                $display("FAIL wrap_addr %0d: req=%b addr=%h required 1/%h",
                         i, bus.imem_req, bus.imem_addr, exp_pc);
            end
            issue(16'h0000, 0);
            tick();
            exp_ret++;
        end
        checks++;
        if (instret !== exp_ret[15:0] || pc !== 8'h02) begin
            failures++;
            $display("FAIL wrap_count: instret=%0d pc=%h required %0d/02", instret, pc, exp_ret);
        end
        issue(16'hF000, 0);
        tick();
        checks++;
        if (halted !== 1'b1) begin
            failures++;
            $display("FAIL halt_entry: halted=%b required 1", halted);
        end
        bus.imem_ack = 1'b1;
        bus.dmem_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({bus.imem_req, bus.WE, bus.W, bus.R, halted} !== 5'b00001 || instret !== exp_ret[15:0]) begin
                failures++;
                $display("FAIL halt_hold cycle %0d: req/WE/W/R/halted=%b instret=%0d required 00001/%0d",
                         i, {bus.imem_req, bus.WE, bus.W, bus.R, halted}, instret, exp_ret);
            end
            tick();
        end
        bus.imem_ack = 1'b0;
        bus.dmem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu_basic();
        test_alu_ops();
        test_sw();
        test_lw();
        test_fetch_wait();
        test_illegal_nop();
        test_reset_mid();
        test_wrap_halt();
        checks++;
        if (wb_q.size() != 0) begin
            failures++;
            $display("FAIL wb_leftover: %0d pending writes, required 0", wb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
